sysid_regs: RTL and testbench

Parametrised system-identification register block for the Nios II Qsys system. It is an Avalon-MM slave that returns a fixed system ID and build timestamp, like a plain sysid. It adds a 64-bit uptime cycle counter with atomic high-word snapshot, a read/write scratch register, a capability word and a configurable number of registered user status words. Reads have a fixed one-cycle latency, signalled with `readdatavalid`; software uses the block to identify and sanity-check the image at boot.

---
 rtl/sysid_regs.sv | 183 ++++++++++++++++++
 tb/tb_sysid_regs.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/sysid_regs.sv
// System-identification register block: ID, build timestamp, scratch, caps and user status words.
// Optional 64-bit uptime counter with atomic high-word snapshot is built when SYSID_UPTIME_EN is defined.
module sysid_regs #(
    parameter logic [31:0] SYSTEM_ID      = 32'h0000_0000,
    parameter logic [31:0] TIMESTAMP      = 32'h0000_0000,
    parameter int          NUM_USER_WORDS = 4,
    parameter int          ADDR_W         = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [ADDR_W-1:0]       address,
    input  logic                    read,
    input  logic                    write,
    input  logic [31:0]             writedata,
    input  logic [3:0]              byteenable,
    output logic [31:0]             readdata,
    output logic                    readdatavalid,
    input  logic [32*((NUM_USER_WORDS > 0) ? NUM_USER_WORDS : 1)-1:0] user_status
);

    localparam int UW        = (NUM_USER_WORDS > 0) ? NUM_USER_WORDS : 1;
    localparam int USER_BASE = 7;

    localparam logic [ADDR_W-1:0] A_ID      = ADDR_W'(0);
    localparam logic [ADDR_W-1:0] A_TS      = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] A_UP_LO   = ADDR_W'(2);
    localparam logic [ADDR_W-1:0] A_UP_HI   = ADDR_W'(3);
    localparam logic [ADDR_W-1:0] A_SCRATCH = ADDR_W'(4);
    localparam logic [ADDR_W-1:0] A_CONTROL = ADDR_W'(5);
    localparam logic [ADDR_W-1:0] A_CAPS    = ADDR_W'(6);

`ifdef SYSID_UPTIME_EN
    localparam logic UPTIME_PRESENT = 1'b1;
`else
    localparam logic UPTIME_PRESENT = 1'b0;
`endif

    localparam logic [15:0] NUM_W16   = 16'(NUM_USER_WORDS);
    localparam logic [31:0] CAPS_WORD = {NUM_W16, 15'b0, UPTIME_PRESENT};

    // Merge new write data into an existing word, one byte lane per enable bit.
    function automatic logic [31:0] byte_merge(
        input logic [31:0] old_word,
        input logic [31:0] new_word,
        input logic [3:0]  be
    );
        logic [31:0] merged;
        merged = old_word;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) begin
                merged[8*b +: 8] = new_word[8*b +: 8];
            end else begin
                merged[8*b +: 8] = old_word[8*b +: 8];
            end
        end
        return merged;
    endfunction

    logic        w_wr_acc;
    logic [31:0] w_rdata;
    logic [31:0] r_readdata;
    logic        r_readdatavalid;
    logic [31:0] r_scratch;
    logic [31:0] r_user [UW];

    // A read in the same cycle wins; the concurrent write is dropped.
    assign w_wr_acc = write & ~read;

    assign readdata      = r_readdata;
    assign readdatavalid = r_readdatavalid;

    // Input register stage for the user status words.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int k = 0; k < UW; k++) begin
                r_user[k] <= 32'h0000_0000;
            end
        end else begin
            for (int k = 0; k < UW; k++) begin
                r_user[k] <= user_status[32*k +: 32];
            end
        end
    end

    // Scratch register with per-byte write enables.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_scratch <= 32'h0000_0000;
        end else if (w_wr_acc && (address == A_SCRATCH)) begin
            r_scratch <= byte_merge(r_scratch, writedata, byteenable);
        end else begin
            r_scratch <= r_scratch;
        end
    end

`ifdef SYSID_UPTIME_EN
    logic [63:0] r_uptime;
    logic [31:0] r_hi_shadow;
    logic        r_freeze;
    logic        w_ctrl_wr;
    logic        w_lo_rd;

    assign w_ctrl_wr = w_wr_acc && (address == A_CONTROL) && byteenable[0];
    assign w_lo_rd   = read && (address == A_UP_LO);

    // Uptime counter: clear beats freeze and increment; wraps naturally at 2^64.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_uptime <= 64'h0;
        end else if (w_ctrl_wr && writedata[0]) begin
            r_uptime <= 64'h0;
        end else if (!r_freeze) begin
            r_uptime <= r_uptime + 64'd1;
        end else begin
            r_uptime <= r_uptime;
        end
    end

    // Freeze control bit.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_freeze <= 1'b0;
        end else if (w_ctrl_wr) begin
            r_freeze <= writedata[1];
        end else begin
            r_freeze <= r_freeze;
        end
    end

    // High-word snapshot taken from the same sample the low-word read returns.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_hi_shadow <= 32'h0000_0000;
        end else if (w_lo_rd) begin
            r_hi_shadow <= r_uptime[63:32];
        end else begin
            r_hi_shadow <= r_hi_shadow;
        end
    end
`endif

    // Read decode; user words and unmapped addresses fall through to the default arm.
    always_comb begin
        w_rdata = 32'h0000_0000;
        case (address)
            A_ID:      w_rdata = SYSTEM_ID;
            A_TS:      w_rdata = TIMESTAMP;
`ifdef SYSID_UPTIME_EN
            A_UP_LO:   w_rdata = r_uptime[31:0];
            A_UP_HI:   w_rdata = r_hi_shadow;
            A_CONTROL: w_rdata = {30'b0, r_freeze, 1'b0};
`endif
            A_SCRATCH: w_rdata = r_scratch;
            A_CAPS:    w_rdata = CAPS_WORD;
            default: begin
                w_rdata = 32'h0000_0000;
                for (int k = 0; k < NUM_USER_WORDS; k++) begin
                    if (address == ADDR_W'(USER_BASE + k)) begin
                        w_rdata = r_user[k];
                    end else begin
                        w_rdata = w_rdata;
                    end
                end
            end
        endcase
    end

    // Registered read port: data held between reads, valid pulses once per read.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_readdata      <= 32'h0000_0000;
            r_readdatavalid <= 1'b0;
        end else begin
            r_readdatavalid <= read;
            if (read) begin
                r_readdata <= w_rdata;
            end else begin
                r_readdata <= r_readdata;
            end
        end
    end

endmodule

// File: tb/tb_sysid_regs.sv
// Scoreboard bench for sysid_regs: expected read data is queued at issue and checked on readdatavalid.
module tb_sysid_regs;

    localparam logic [31:0] SYSID = 32'h5DEC_0A17;
    localparam logic [31:0] TSTMP = 32'd1575783191;
`ifdef SYSID_UPTIME_EN
    localparam logic [31:0] CAPS_EXP = 32'h0004_0001;
`else
    localparam logic [31:0] CAPS_EXP = 32'h0004_0000;
`endif

    logic         clock = 1'b0;
    logic         reset;
    logic [3:0]   address;
    logic         read;
    logic         write;
    logic [31:0]  writedata;
    logic [3:0]   byteenable;
    logic [31:0]  readdata;
    logic         readdatavalid;
    logic [127:0] user_status;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] sb_exp[$];
    string       sb_tag[$];

    logic        exp_rdv  = 1'b0;
    logic        rst_seen = 1'b1;
    logic [31:0] hold_exp = 32'h0;

    sysid_regs #(
        .SYSTEM_ID      (SYSID),
        .TIMESTAMP      (TSTMP),
        .NUM_USER_WORDS (4),
        .ADDR_W         (4)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .address       (address),
        .read          (read),
        .write         (write),
        .writedata     (writedata),
        .byteenable    (byteenable),
        .readdata      (readdata),
        .readdatavalid (readdatavalid),
        .user_status   (user_status)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // A read is expected back one cycle later unless reset was sampled with it.
    always @(posedge clock) begin
        exp_rdv  <= read && !reset;
        rst_seen <= reset;
    end

`ifdef SYSID_UPTIME_EN
    logic [63:0] m_up  = 64'h0;
    logic        m_frz = 1'b0;
    logic        m_ctrl_wr;
    assign m_ctrl_wr = write && !read && (address == 4'd5) && byteenable[0];

    always @(posedge clock) begin
        if (reset) begin
            m_up  <= 64'h0;
            m_frz <= 1'b0;
        end else begin
            if (m_ctrl_wr) m_frz <= writedata[1];
            if (m_ctrl_wr && writedata[0]) m_up <= 64'h0;
            else if (!m_frz) m_up <= m_up + 64'd1;
        end
    end
`endif

    always @(negedge clock) begin : monitor
        logic [31:0] e;
        string       t;
        check_eq("rdv", {31'b0, readdatavalid}, {31'b0, exp_rdv});
        if (rst_seen) begin
            check_eq("rst_rdata", readdata, 32'h0);
            hold_exp <= 32'h0;
        end else if (readdatavalid) begin
            if (sb_exp.size() == 0) begin
                check_eq("sb_empty", 32'd1, 32'd0);
            end else begin
                e = sb_exp.pop_front();
                t = sb_tag.pop_front();
                check_eq(t, readdata, e);
                hold_exp <= e;
            end
        end else begin
            check_eq("hold", readdata, hold_exp);
        end
    end

    task automatic rd(input logic [3:0] a, input logic [31:0] e, input string t);
        address = a; read = 1'b1; write = 1'b0;
        sb_exp.push_back(e); sb_tag.push_back(t);
        @(negedge clock);
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
        address = a; read = 1'b0; write = 1'b1; writedata = d; byteenable = be;
        @(negedge clock);
    endtask

    task automatic rdwr(input logic [3:0] a, input logic [31:0] d, input logic [31:0] e, input string t);
        address = a; read = 1'b1; write = 1'b1; writedata = d; byteenable = 4'hF;
        sb_exp.push_back(e); sb_tag.push_back(t);
        @(negedge clock);
    endtask

    task automatic idle(input int n);
        read = 1'b0; write = 1'b0;
        repeat (n) @(negedge clock);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; read = 1'b0; write = 1'b0; address = 4'd0;
        writedata = 32'h0; byteenable = 4'h0; user_status = 128'h0;
        repeat (2) @(negedge clock);
        read = 1'b1; address = 4'd1;          // ignored while in reset
        @(negedge clock);
        read = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        idle(1);

        rd(4'd0, SYSID, "id");
        rd(4'd1, TSTMP, "ts");
        rd(4'd6, CAPS_EXP, "caps");
        idle(2);

        rd(4'd4, 32'h0, "scratch_rst");
        wr(4'd4, 32'hAABB_CCDD, 4'b1111);
        wr(4'd4, 32'h1122_3344, 4'b0101);
        rd(4'd4, 32'hAA22_CC44, "scratch_be");
        wr(4'd4, 32'hFFFF_FFFF, 4'b1000);
        rd(4'd4, 32'hFF22_CC44, "scratch_be3");
        wr(4'd4, 32'h0000_0000, 4'b0000);
        rd(4'd4, 32'hFF22_CC44, "scratch_be0");

        wr(4'd0, 32'hFFFF_FFFF, 4'hF);
        wr(4'd6, 32'hFFFF_FFFF, 4'hF);
        wr(4'd15, 32'hFFFF_FFFF, 4'hF);
        rd(4'd0, SYSID, "id_ro");
        rd(4'd6, CAPS_EXP, "caps_ro");
        rd(4'd15, 32'h0, "unmapped");

        rdwr(4'd4, 32'h0000_0001, 32'hFF22_CC44, "rdwr_old");
        rd(4'd4, 32'hFF22_CC44, "rdwr_kept");
        idle(1);

        user_status = {32'h3333_3333, 32'hCAFE_F00D, 32'h1111_1111, 32'h0000_0000};
        idle(1);
        rd(4'd9, 32'hCAFE_F00D, "user2");
        rd(4'd7, 32'h0000_0000, "user0");
        rd(4'd8, 32'h1111_1111, "user1");
        rd(4'd10, 32'h3333_3333, "user3");
        rd(4'd11, 32'h0, "user_oob");
        rd(4'd15, 32'h0, "addr15");
        user_status[95:64] = 32'h1234_5678;
        rd(4'd9, 32'hCAFE_F00D, "user_stage");
        rd(4'd9, 32'h1234_5678, "user_new");
        idle(2);

`ifdef SYSID_UPTIME_EN
        rd(4'd2, m_up[31:0], "up_lo");
        rd(4'd3, 32'h0, "up_hi");
        wr(4'd5, 32'h0000_0002, 4'hF);
        idle(10);
        rd(4'd2, m_up[31:0], "frz_lo1");
        rd(4'd2, m_up[31:0], "frz_lo2");
        rd(4'd5, 32'h0000_0002, "ctrl_frz");
        wr(4'd5, 32'h0000_0003, 4'hF);
        rd(4'd2, 32'h0, "clr_lo");
        idle(5);
        rd(4'd2, 32'h0, "clr_hold");
        rd(4'd5, 32'h0000_0002, "ctrl_rb");
        wr(4'd5, 32'h0000_0000, 4'b1110);     // no byte 0: freeze stays set
        rd(4'd5, 32'h0000_0002, "ctrl_be");
        wr(4'd5, 32'h0000_0000, 4'hF);
        idle(3);
        rd(4'd2, m_up[31:0], "run_lo");
        idle(1);

        address = 4'd2; read = 1'b1; write = 1'b0;
        force dut.r_uptime = 64'h0000_0000_FFFF_FFFF;
        sb_exp.push_back(32'hFFFF_FFFF); sb_tag.push_back("up_lo_force");
        @(negedge clock);
        release dut.r_uptime;
        idle(4);
        rd(4'd3, 32'h0000_0000, "up_hi_shadow");
        idle(1);
`else
        rd(4'd2, 32'h0, "no_up_lo");
        rd(4'd3, 32'h0, "no_up_hi");
        wr(4'd5, 32'h0000_0002, 4'hF);
        rd(4'd5, 32'h0, "no_ctrl");
        idle(1);
`endif

        address = 4'd4; read = 1'b1; reset = 1'b1;   // read sampled with reset is dropped
        @(negedge clock);
        read = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        rd(4'd9, 32'h0, "user_rst");
        rd(4'd4, 32'h0, "scratch_post_rst");
        idle(1);

        for (int i = 0; i < 10 && sb_exp.size() != 0; i++) @(negedge clock);
        check_eq("drain", 32'(sb_exp.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
